// File: rtl/byte_loader_pkg.sv
// byte_loader_pkg: shared state type and width helpers for byte_pair_loader.
package byte_loader_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SECOND, COMMIT} loader_state_t;

    function automatic int byte_w(input int n);
        return n / 2;
    endfunction

    function automatic int timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: counts consecutive enabled cycles and flags the cycle that reaches TIMEOUT.
module idle_timer
    import byte_loader_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic clear_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = timer_w(TIMEOUT);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = en && (cnt_q == TW'(TIMEOUT - 1));
        cnt_d   = (clr || expired) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/byte_pair_loader.sv
// byte_pair_loader: pairs handshaked bytes into words and drives a split-load register
// so both halves update on the same edge; adds order select, timeout, flush and word count.
module byte_pair_loader
    import byte_loader_pkg::*;
#(
    parameter int N       = 16,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic [byte_w(N)-1:0]   in_byte,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   msb_first,
    input  logic                   flush,
    output logic [byte_w(N)-1:0]   inh,
    output logic [byte_w(N)-1:0]   inl,
    output logic                   loadh,
    output logic                   loadl,
    output logic                   reg_clear,
    output logic                   word_done,
    output logic [CNT_W-1:0]       word_count,
    output logic                   err_timeout
);

    localparam int BW = byte_w(N);

    loader_state_t   state_q;
    logic [BW-1:0]   stage_q, inh_q, inl_q;
    logic [CNT_W-1:0] count_q;
    logic            order_q, loadh_q, loadl_q, clear_q, done_q, err_q;
    logic            accept, expired;

    assign in_ready = clear_n && !flush && (state_q == IDLE || state_q == WAIT_SECOND);
    assign accept   = in_valid && in_ready;

    // Timer runs only while waiting for the second byte and nothing arrives.
    idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .clear_n (clear_n),
        .clr     (flush || state_q != WAIT_SECOND),
        .en      (state_q == WAIT_SECOND && !accept && !flush),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            order_q <= 1'b0;
            inh_q   <= '0;
            inl_q   <= '0;
            loadh_q <= 1'b0;
            loadl_q <= 1'b0;
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            loadh_q <= 1'b0;
            loadl_q <= 1'b0;
            done_q  <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                stage_q <= '0;
                clear_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        stage_q <= in_byte;
                        order_q <= msb_first;
                        state_q <= WAIT_SECOND;
                    end
                    WAIT_SECOND: if (accept) begin
                        inh_q   <= order_q ? stage_q : in_byte;
                        inl_q   <= order_q ? in_byte : stage_q;
                        loadh_q <= 1'b1;
                        loadl_q <= 1'b1;
                        done_q  <= 1'b1;
                        count_q <= count_q + 1'b1;
                        state_q <= COMMIT;
                    end else if (expired) begin
                        stage_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign inh         = inh_q;
    assign inl         = inl_q;
    assign loadh       = loadh_q;
    assign loadl       = loadl_q;
    assign reg_clear   = clear_q;
    assign word_done   = done_q;
    assign word_count  = count_q;
    assign err_timeout = err_q;

endmodule
